// File: rtl/reg_file_pkg.sv
// Shared memory-subsystem types and helpers used by register files, FIFOs and RAM wrappers.
// Read-port payload is sized for the widest supported word (RP_DW); narrower users zero-extend.
package reg_file_pkg;

  localparam int RP_DW = 64;

  typedef struct packed {
    logic [RP_DW-1:0] data;
    logic             valid;
  } rd_port_t;

  function automatic int mem_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Write/clear/read bundle of the register file; master drives requests, slave returns read data.
// All slave outputs are registered, so the bundle carries no combinational return paths.
interface reg_file_if import reg_file_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) ();

  localparam int AW = mem_clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             clr;
  logic [AW-1:0]    raddr0;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             rvalid0;
  logic             rvalid1;
  logic             wr_err;

  modport master (
    output we, waddr, wdata, clr, raddr0, raddr1,
    input  rdata0, rdata1, rvalid0, rvalid1, wr_err
  );

  modport slave (
    input  we, waddr, wdata, clr, raddr0, raddr1,
    output rdata0, rdata1, rvalid0, rvalid1, wr_err
  );

endinterface

// File: rtl/reg_file_en_reg.sv
// Enable-gated register with async active-low reset; q updates one edge after en, holds otherwise.
// No backpressure: the enable is the only qualifier.
module en_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= en ? d : q;
  end

endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file, one write and two registered read ports, valid tracking, clear, bypass.
// Read latency 1 cycle; no backpressure, every port samples each edge. WIDTH must not exceed RP_DW.
module reg_file import reg_file_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  reg_file_if.slave   bus
);

  localparam int AW = mem_clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic [WIDTH-1:0] entry_d;
  logic             w_in_range;
  logic             w_ok;
  logic             wr_err_q;
  logic [AW-1:0]    raddr [2];

  assign w_in_range = int'(bus.waddr) < DEPTH;
  assign w_ok       = bus.we && !bus.clr && w_in_range;
  assign entry_d    = bus.clr ? '0 : bus.wdata;
  assign raddr[0]   = bus.raddr0;
  assign raddr[1]   = bus.raddr1;

  // Clear rides the same enable as a write, loading zero into every entry.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic hit;
    assign hit = bus.clr || (w_ok && bus.waddr == AW'(i));
    en_reg #(.WIDTH(WIDTH)) u_entry (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (hit),
      .d     (entry_d),
      .q     (mem[i])
    );
  end

  always_comb begin
    valid_nxt = valid;
    if (bus.clr) begin
      valid_nxt = '0;
    end else if (w_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.waddr == AW'(i)) valid_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      valid    <= valid_nxt;
      wr_err_q <= bus.we && !bus.clr && !w_in_range;
    end
  end

  // Out-of-range read addresses match no entry and fall through to zero/invalid.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    rd_port_t   nxt;
    logic [WIDTH:0] q;
    logic       unused_hi;

    always_comb begin
      nxt = '0;
      if (bus.clr) begin
        nxt = '0;
      end else if (BYPASS != 0 && w_ok && raddr[p] == bus.waddr) begin
        nxt.data  = RP_DW'(bus.wdata);
        nxt.valid = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (raddr[p] == AW'(i)) begin
            nxt.data  = RP_DW'(mem[i]);
            nxt.valid = valid[i];
          end
        end
      end
    end

    assign unused_hi = ^nxt.data;

    en_reg #(.WIDTH(WIDTH + 1)) u_rd (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (1'b1),
      .d     ({nxt.data[WIDTH-1:0], nxt.valid}),
      .q     (q)
    );
  end

  assign bus.rdata0  = g_rd[0].q[WIDTH:1];
  assign bus.rvalid0 = g_rd[0].q[0];
  assign bus.rdata1  = g_rd[1].q[WIDTH:1];
  assign bus.rvalid1 = g_rd[1].q[0];
  assign bus.wr_err  = wr_err_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: DUT A (DEPTH 8, bypass) and DUT B (DEPTH 6, no bypass) driven in lockstep,
// expected outputs from a behavioural model queued at drive time and compared after each edge.
module tb_reg_file;

  typedef struct packed {
    logic [7:0] rd0;
    logic       rv0;
    logic [7:0] rd1;
    logic       rv1;
    logic       err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(8), .DEPTH(8)) bus_a ();
  reg_file_if #(.WIDTH(8), .DEPTH(6)) bus_b ();

  reg_file #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  reg_file #(.WIDTH(8), .DEPTH(6), .BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int         depth  [2] = '{8, 6};
  int         bypass [2] = '{1, 0};
  logic [7:0] m_mem  [2][8];
  logic       m_val  [2][8];
  obs_t       exp_q [$];
  obs_t       got_q [$];
  obs_t       e_o, g_o, last_a, last_b;
  int         k;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic obs_t sample(input int d);
    if (d == 0) return {bus_a.rdata0, bus_a.rvalid0, bus_a.rdata1, bus_a.rvalid1, bus_a.wr_err};
    return {bus_b.rdata0, bus_b.rvalid0, bus_b.rdata1, bus_b.rvalid1, bus_b.wr_err};
  endfunction

  function automatic logic [8:0] m_read(input int d, input logic we, input int wa,
                                         input logic [7:0] wd, input logic clr, input int ra);
    if (clr) return 9'h0;
    if (bypass[d] == 1 && we && wa < depth[d] && ra == wa) return {wd, 1'b1};
    if (ra < depth[d]) return {m_mem[d][ra], m_val[d][ra]};
    return 9'h0;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        m_mem[d][i] = 8'h00;
        m_val[d][i] = 1'b0;
      end
  endtask

  task automatic drive(input logic we, input int wa, input logic [7:0] wd,
                       input logic clr, input int r0, input int r1);
    bus_a.we = we; bus_a.waddr = 3'(wa); bus_a.wdata = wd; bus_a.clr = clr;
    bus_a.raddr0 = 3'(r0); bus_a.raddr1 = 3'(r1);
    bus_b.we = we; bus_b.waddr = 3'(wa); bus_b.wdata = wd; bus_b.clr = clr;
    bus_b.raddr0 = 3'(r0); bus_b.raddr1 = 3'(r1);
  endtask

  task automatic step(input logic we, input int wa, input logic [7:0] wd,
                      input logic clr, input int r0, input int r1);
    obs_t e;
    drive(we, wa, wd, clr, r0, r1);
    for (int d = 0; d < 2; d++) begin
      e = {m_read(d, we, wa, wd, clr, r0), m_read(d, we, wa, wd, clr, r1),
           we && !clr && (wa >= depth[d])};
      exp_q.push_back(e);
    end
    for (int d = 0; d < 2; d++) begin
      if (clr) begin
        for (int i = 0; i < 8; i++) begin
          m_mem[d][i] = 8'h00;
          m_val[d][i] = 1'b0;
        end
      end else if (we && wa < depth[d]) begin
        m_mem[d][wa] = wd;
        m_val[d][wa] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    got_q.push_back(sample(0));
    got_q.push_back(sample(1));
  endtask

  task automatic test_reset();
    drive(1'b0, 0, 8'h00, 1'b0, 0, 0);
    m_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      g_o = sample(d);
      n_cmp++;
      if (g_o !== 19'h0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got %h required 0", d, g_o);
      end
    end
    #20 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 0, 8'h00, 1'b0, i, 7 - i);
    k = 0;
    while (exp_q.size() > 0) begin
      e_o = exp_q.pop_front(); g_o = got_q.pop_front(); n_cmp++;
      if (g_o !== e_o) begin
        n_bad++;
        $display("FAIL reset_read[%0d]: got %h required %h", k, g_o, e_o);
      end
      k++;
    end
  endtask

  task automatic test_write_read();
    step(1'b1, 3, 8'hA5, 1'b0, 0, 0);
    step(1'b0, 0, 8'h00, 1'b0, 3, 4);
    k = 0;
    while (exp_q.size() > 0) begin
      e_o = exp_q.pop_front(); g_o = got_q.pop_front(); n_cmp++;
      if (g_o !== e_o) begin
        n_bad++;
        $display("FAIL write_read[%0d]: got %h required %h", k, g_o, e_o);
      end
      if (k % 2 == 0) last_a = g_o; else last_b = g_o;
      k++;
    end
    n_cmp++;
    if (last_a.rd0 !== 8'hA5 || last_a.rv0 !== 1'b1 || last_a.rd1 !== 8'h00 || last_a.rv1 !== 1'b0) begin
      n_bad++;
      $display("FAIL write_read_a3: got %h required rd0=a5 rv0=1 rd1=00 rv1=0", last_a);
    end
  endtask

  task automatic test_bypass();
    step(1'b1, 5, 8'h3C, 1'b0, 5, 5);
    k = 0;
    while (exp_q.size() > 0) begin
      e_o = exp_q.pop_front(); g_o = got_q.pop_front(); n_cmp++;
      if (g_o !== e_o) begin
        n_bad++;
        $display("FAIL bypass[%0d]: got %h required %h", k, g_o, e_o);
      end
      if (k % 2 == 0) last_a = g_o; else last_b = g_o;
      k++;
    end
    n_cmp++;
    if (last_a !== {8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL bypass_on: got %h required both ports 3c valid", last_a);
    end
    n_cmp++;
    if (last_b !== 19'h0) begin
      n_bad++;
      $display("FAIL bypass_off: got %h required old contents 0", last_b);
    end
    step(1'b0, 0, 8'h00, 1'b0, 5, 5);
    k = 0;
    while (exp_q.size() > 0) begin
      e_o = exp_q.pop_front(); g_o = got_q.pop_front(); n_cmp++;
      if (g_o !== e_o) begin
        n_bad++;
        $display("FAIL bypass_after[%0d]: got %h required %h", k, g_o, e_o);
      end
      k++;
    end
  endtask

  task automatic test_illegal();
    step(1'b1, 7, 8'hFF, 1'b0, 7, 0);
    step(1'b1, 6, 8'hEE, 1'b0, 6, 3);
    step(1'b0, 0, 8'h00, 1'b0, 7, 6);
    step(1'b0, 0, 8'h00, 1'b0, 7, 6);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 8'h00, 1'b0, i, 5 - i);
    k = 0;
    while (exp_q.size() > 0) begin
      e_o = exp_q.pop_front(); g_o = got_q.pop_front(); n_cmp++;
      if (g_o !== e_o) begin
        n_bad++;
        $display("FAIL illegal_write[%0d]: got %h required %h", k, g_o, e_o);
      end
      k++;
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 8; i++) step(1'b1, i, 8'(8'h11 * (i + 1)), 1'b0, i, 7 - i);
    step(1'b1, 2, 8'h11, 1'b1, 2, 2);
    step(1'b1, 7, 8'h22, 1'b1, 0, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 8'h00, 1'b0, i, 7 - i);
    k = 0;
    while (exp_q.size() > 0) begin
      e_o = exp_q.pop_front(); g_o = got_q.pop_front(); n_cmp++;
      if (g_o !== e_o) begin
        n_bad++;
        $display("FAIL clear[%0d]: got %h required %h", k, g_o, e_o);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back();
    int wa;
    for (int n = 0; n < 300; n++) begin
      wa = int'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), wa, 8'($urandom), 1'($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)));
    end
    k = 0;
    while (exp_q.size() > 0) begin
      e_o = exp_q.pop_front(); g_o = got_q.pop_front(); n_cmp++;
      if (g_o !== e_o) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %h required %h", k, g_o, e_o);
      end
      k++;
    end
  endtask

  task automatic test_reset_mid_write();
    step(1'b1, 1, 8'h55, 1'b0, 1, 1);
    step(1'b0, 0, 8'h00, 1'b0, 1, 1);
    drive(1'b1, 1, 8'h77, 1'b0, 1, 1);
    #3 rst_n = 1'b0;
    #1;
    m_reset();
    for (int d = 0; d < 2; d++) begin
      g_o = sample(d);
      n_cmp++;
      if (g_o !== 19'h0) begin
        n_bad++;
        $display("FAIL async_reset[%0d]: got %h required 0", d, g_o);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1'b0, 0, 8'h00, 1'b0, 1, 1);
    k = 0;
    while (exp_q.size() > 0) begin
      e_o = exp_q.pop_front(); g_o = got_q.pop_front(); n_cmp++;
      if (g_o !== e_o) begin
        n_bad++;
        $display("FAIL reset_mid_write[%0d]: got %h required %h", k, g_o, e_o);
      end
      if (k % 2 == 0) last_a = g_o; else last_b = g_o;
      k++;
    end
    n_cmp++;
    if (last_a.rd0 !== 8'h00 || last_a.rv0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_discard_a1: got rd0=%h rv0=%b required 00/0", last_a.rd0, last_a.rv0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_illegal();
    test_clear();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-entry register file for the memory subsystem, built from enable-gated registers. It generalises the single enable-DFF register to DEPTH words of WIDTH bits and adds:
- one write port and two read ports with registered outputs;
- per-entry valid tracking, synchronous clear and write-to-read bypass;
- out-of-range write detection.

It serves as the local operand store for datapath blocks that previously instantiated single enable registers one by one.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 8, number of entries (≥2, need not be a power of two)
- AW, $clog2(DEPTH), address width; derived, not overridden
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns old contents

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  WIDTH  write data
- clr  in  1  synchronous clear of all entries and valid bits
- raddr0  in  AW  read address, port 0
- raddr1  in  AW  read address, port 1
- rdata0  out  WIDTH  registered read data, port 0
- rdata1  out  WIDTH  registered read data, port 1
- rvalid0  out  1  registered: entry raddr0 has been written since last reset/clear
- rvalid1  out  1  same for port 1
- wr_err  out  1  registered one-cycle pulse: write attempted with waddr ≥ DEPTH

## Operation
- Storage: DEPTH × WIDTH data array plus DEPTH-bit valid vector.
- Write: when we=1, clr=0 and waddr<DEPTH, entry waddr ← wdata and valid[waddr] ← 1 at the clock edge.
  - Rewriting an entry with the same data is a normal write.
- Illegal write: when we=1 and waddr≥DEPTH, nothing is stored and wr_err=1 for the next cycle.
- Clear: when clr=1, all entries become 0 and all valid bits become 0. clr overrides we; the write is dropped and wr_err stays 0.
- Read: each port samples independently every cycle, with no enable.
  - rdataN ← entry[raddrN] and rvalidN ← valid[raddrN].
  - When raddrN ≥ DEPTH: rdataN ← 0 and rvalidN ← 0.
- Bypass (BYPASS=1): on a legal write with clr=0 and raddrN==waddr, rdataN ← wdata and rvalidN ← 1.
  - Both ports may bypass in the same cycle.
- No bypass (BYPASS=0): a read that collides with a write returns the pre-write contents and pre-write valid bit.
- Read during clr: rdataN ← 0 and rvalidN ← 0, regardless of BYPASS.

## Timing
- Reset (rst_n=0, asynchronous, immediate): all entries 0, valid vector 0, rdata0=rdata1=0, rvalid0=rvalid1=0, wr_err=0.
  - Reset asserted mid-write discards that write.
  - After deassertion the first edge behaves normally.
- Read latency: 1 cycle. Address presented at edge k yields data after edge k+1.
- Write-to-read latency: 0 extra cycles with BYPASS=1; 1 extra cycle with BYPASS=0.
- wr_err: asserted for exactly the cycle after the offending edge. Back-to-back illegal writes keep it high continuously.
- Outputs are held between edges; there are no combinational paths from inputs to outputs.

## Structure
- Shared memory package holds:
  - the address-width function (clog2 helper);
  - a read-port struct {data, valid}, reused by later FIFO/RAM blocks.
- Sub-module en_reg: parametrised WIDTH enable register with async active-low reset (mux-feedback style).
  - Instantiated DEPTH times via generate for the data array.
  - Instantiated twice for the read output registers.
- Valid vector, bypass compare and wr_err live in the top module.

## Test plan
- Reset, then read all 8 addresses on both ports → rdata=0, rvalid=0 everywhere; wr_err=0.
- Write 0xA5 to addr 3; next cycle read addr 3 on port 0 and addr 4 on port 1 → rdata0=0xA5, rvalid0=1; rdata1=0, rvalid1=0.
- Same cycle: write 0x3C to addr 5 while raddr0=raddr1=5.
  - BYPASS=1 → both ports return 0x3C with rvalid=1.
  - BYPASS=0 → both return the old value (0 with rvalid=0 after reset).
- DEPTH=6: write 0xFF to addr 7 → wr_err=1 for one cycle; then read addr 7 → rdata=0, rvalid=0; entries 0–5 unchanged.
- Fill all entries, then assert clr together with we to addr 2 (0x11) → next cycle read addr 2 returns 0, rvalid=0; all entries read 0.
- Drop rst_n between edges during a write to addr 1 → outputs 0 immediately; after release, addr 1 reads 0 with rvalid=0.
